// File: rtl/dla_pkg.sv
// dla_pkg: shared state, direction and colour definitions
// for the diffusion-limited-aggregation stages.
package dla_pkg;

  localparam int I_IDLE  = 0;
  localparam int I_SEED  = 1;
  localparam int I_SPAWN = 2;
  localparam int I_CHECK = 3;
  localparam int I_WAIT  = 4;
  localparam int I_MOVE  = 5;
  localparam int I_WRITE = 6;
  localparam int I_DONE  = 7;

  typedef enum logic [7:0] {
    ST_IDLE  = 8'b0000_0001,
    ST_SEED  = 8'b0000_0010,
    ST_SPAWN = 8'b0000_0100,
    ST_CHECK = 8'b0000_1000,
    ST_WAIT  = 8'b0001_0000,
    ST_MOVE  = 8'b0010_0000,
    ST_WRITE = 8'b0100_0000,
    ST_DONE  = 8'b1000_0000
  } state_e;

  typedef logic [2:0] dir_t;

  localparam dir_t DIR_N  = 3'd0;
  localparam dir_t DIR_NE = 3'd1;
  localparam dir_t DIR_E  = 3'd2;
  localparam dir_t DIR_SE = 3'd3;
  localparam dir_t DIR_S  = 3'd4;
  localparam dir_t DIR_SW = 3'd5;
  localparam dir_t DIR_W  = 3'd6;
  localparam dir_t DIR_NW = 3'd7;

  localparam logic PIXEL_ON = 1'b1;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/dla_lfsr.sv
// dla_lfsr: Galois LFSR with enable and parallel output,
// shared by the DLA stages.
module dla_lfsr
  import dla_pkg::*;
#(
  parameter int           W    = 16,
  parameter logic [W-1:0] SEED = W'(16'hACE1),
  parameter logic [W-1:0] TAPS = W'(LFSR_TAPS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = (q_q >> 1) ^ (q_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/dla_particle_walk.sv
// dla_particle_walk: random-walk controller for the DLA demo.
// DLA_WALK_DIAG_EN selects the 8-direction walk (default 4).
module dla_particle_walk
  import dla_pkg::*;
#(
  parameter int          AVN_AW       = 18,
  parameter int          AVN_DW       = 16,
  parameter int          HSIZE        = 640,
  parameter int          VSIZE        = 480,
  parameter int          NUM_PARTICLE = 2000,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              particle_cnt,
  output logic [$clog2(HSIZE)-1:0] check_x,
  output logic [$clog2(VSIZE)-1:0] check_y,
  output logic                     check_start,
  input  logic                     check_done,
  input  logic                     hit_boundary,
  input  logic                     hit_neighbor,
  output logic [AVN_AW-1:0]        vram_avn_address,
  output logic                     vram_avn_write,
  output logic [AVN_DW-1:0]        vram_avn_writedata,
  input  logic                     vram_avn_waitrequest
);

  localparam int XW = $clog2(HSIZE);
  localparam int YW = $clog2(VSIZE);
  localparam logic [XW-1:0] X_MAX = XW'(HSIZE - 2);
  localparam logic [YW-1:0] Y_MAX = YW'(VSIZE - 2);

  state_e          state_q;
  state_e          state_d;
  logic [XW-1:0]   x_q;
  logic [XW-1:0]   x_d;
  logic [YW-1:0]   y_q;
  logic [YW-1:0]   y_d;
  logic [15:0]     cnt_q;
  logic [15:0]     cnt_d;
  logic            seed_q;
  logic            seed_d;
  logic [15:0]     lfsr;
  logic [XW+YW-1:0] rnd;
  logic [XW-1:0]   rx;
  logic [YW-1:0]   ry;
  logic            ok;
  dir_t            dir;

  dla_lfsr #(
    .W    (16),
    .SEED (SEED),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en_i (!state_q[I_IDLE]),
    .q_o  (lfsr)
  );

  // coordinate fields wider than the LFSR wrap around it
  assign rnd = (XW+YW)'({lfsr, lfsr});
  assign rx  = rnd[XW-1:0];
  assign ry  = rnd[XW +: YW];
  assign ok  = (rx != '0) && (rx <= X_MAX)
            && (ry != '0) && (ry <= Y_MAX);

`ifdef DLA_WALK_DIAG_EN
  assign dir = lfsr[2:0];
`else
  assign dir = {lfsr[1:0], 1'b0};
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    seed_d  = seed_q;
    unique case (1'b1)
      state_q[I_IDLE]: begin
        if (start) begin
          cnt_d   = '0;
          state_d = ST_SEED;
        end
      end
      state_q[I_SEED]: begin
        x_d     = XW'(HSIZE / 2);
        y_d     = YW'(VSIZE / 2);
        seed_d  = 1'b1;
        state_d = ST_WRITE;
      end
      state_q[I_SPAWN]: begin
        if (ok) begin
          x_d     = rx;
          y_d     = ry;
          state_d = ST_CHECK;
        end
      end
      state_q[I_CHECK]: state_d = ST_WAIT;
      state_q[I_WAIT]: begin
        if (check_done) begin
          if (hit_boundary)      state_d = ST_SPAWN;
          else if (hit_neighbor) state_d = ST_WRITE;
          else                   state_d = ST_MOVE;
        end
      end
      state_q[I_MOVE]: begin
        case (dir)
          DIR_NE, DIR_E, DIR_SE: x_d = x_q + 1'b1;
          DIR_NW, DIR_W, DIR_SW: x_d = x_q - 1'b1;
          default: ;
        endcase
        case (dir)
          DIR_SE, DIR_S, DIR_SW: y_d = y_q + 1'b1;
          DIR_NE, DIR_N, DIR_NW: y_d = y_q - 1'b1;
          default: ;
        endcase
        state_d = ST_CHECK;
      end
      state_q[I_WRITE]: begin
        if (!vram_avn_waitrequest) begin
          seed_d  = 1'b0;
          state_d = ST_SPAWN;
          if (!seed_q) begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_d == 16'(NUM_PARTICLE)) state_d = ST_DONE;
          end
        end
      end
      state_q[I_DONE]: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      seed_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      seed_q  <= seed_d;
    end
  end

  assign busy         = !(state_q[I_IDLE] || state_q[I_DONE]);
  assign done         = state_q[I_DONE];
  assign check_start  = state_q[I_CHECK];
  assign check_x      = x_q;
  assign check_y      = y_q;
  assign particle_cnt = cnt_q;

  assign vram_avn_write     = state_q[I_WRITE];
  assign vram_avn_address   = AVN_AW'(x_q)
                            + AVN_AW'(y_q) * AVN_AW'(HSIZE);
  assign vram_avn_writedata = {AVN_DW{PIXEL_ON}};

endmodule

// File: tb/tb_dla_particle_walk.sv
// tb_dla_particle_walk: directed and randomized checks of the
// walk controller against a behavioural checker/VRAM model.
module tb_dla_particle_walk;

  localparam int HS = 16;
  localparam int VS = 12;
  localparam int NP = 3;
  localparam int XW = $clog2(HS);
  localparam int YW = $clog2(VS);
  localparam int SEED_ADDR = HS / 2 + (VS / 2) * HS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic check_done = 1'b0;
  logic hit_boundary = 1'b0;
  logic hit_neighbor = 1'b0;
  logic vram_avn_waitrequest = 1'b1;

  logic          busy;
  logic          done;
  logic [15:0]   particle_cnt;
  logic [XW-1:0] check_x;
  logic [YW-1:0] check_y;
  logic          check_start;
  logic [17:0]   vram_avn_address;
  logic          vram_avn_write;
  logic [15:0]   vram_avn_writedata;

  int errors = 0;
  int checks = 0;

  dla_particle_walk #(
    .AVN_AW       (18),
    .AVN_DW       (16),
    .HSIZE        (HS),
    .VSIZE        (VS),
    .NUM_PARTICLE (NP),
    .SEED         (16'hACE1)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .busy                 (busy),
    .done                 (done),
    .particle_cnt         (particle_cnt),
    .check_x              (check_x),
    .check_y              (check_y),
    .check_start          (check_start),
    .check_done           (check_done),
    .hit_boundary         (hit_boundary),
    .hit_neighbor         (hit_neighbor),
    .vram_avn_address     (vram_avn_address),
    .vram_avn_write       (vram_avn_write),
    .vram_avn_writedata   (vram_avn_writedata),
    .vram_avn_waitrequest (vram_avn_waitrequest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit in_range(int x, int y);
    return x >= 1 && x <= HS - 2 && y >= 1 && y <= VS - 2;
  endfunction

  function automatic bit on_edge(int x, int y);
    return x == 0 || x == HS - 1 || y == 0 || y == VS - 1;
  endfunction

  function automatic bit adjacent(int ax, int ay, int bx, int by);
    int dx;
    int dy;
    dx = ax > bx ? ax - bx : bx - ax;
    dy = ay > by ? ay - by : by - ay;
`ifdef DLA_WALK_DIAG_EN
    return dx <= 1 && dy <= 1 && (dx + dy) > 0;
`else
    return (dx + dy) == 1;
`endif
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_cstart"}, 32'(check_start), 0);
    chk({tag, "_write"}, 32'(vram_avn_write), 0);
    chk({tag, "_cnt"}, 32'(particle_cnt), 0);
    chk({tag, "_x"}, 32'(check_x), 0);
    chk({tag, "_y"}, 32'(check_y), 0);
    chk({tag, "_addr"}, 32'(vram_avn_address), 0);
  endtask

  // starts a run and checks the seed write is issued 2 cycles later
  task automatic start_run(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_lat1"}, 32'(vram_avn_write), 0);
    chk({tag, "_cnt_clr"}, 32'(particle_cnt), 0);
    @(negedge clk);
    chk({tag, "_lat2"}, 32'(vram_avn_write), 1);
  endtask

  task automatic wait_check(output int cx, output int cy,
                            output bit wrote);
    bit seen;
    seen  = 1'b0;
    wrote = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (vram_avn_write) wrote = 1'b1;
      if (check_start) seen = 1'b1;
    end
    chk("check_start_seen", 32'(seen), 1);
    cx = int'(check_x);
    cy = int'(check_y);
  endtask

  // called in the CHECK cycle; answers after lat idle WAIT cycles
  task automatic respond(input int lat, input bit hb, input bit hn);
    bit stable;
    int cx;
    int cy;
    stable = 1'b1;
    cx = int'(check_x);
    cy = int'(check_y);
    @(negedge clk);
    repeat (lat) begin
      if (int'(check_x) != cx || int'(check_y) != cy) stable = 1'b0;
      @(negedge clk);
    end
    if (int'(check_x) != cx || int'(check_y) != cy) stable = 1'b0;
    chk("wait_hold", 32'(stable), 1);
    check_done   = 1'b1;
    hit_boundary = hb;
    hit_neighbor = hn;
    @(negedge clk);
    check_done   = 1'b0;
    hit_boundary = 1'b0;
    hit_neighbor = 1'b0;
  endtask

  task automatic move_step(input int lat, input bit stray,
                           inout int px, inout int py);
    int nx;
    int ny;
    respond(lat, 1'b0, 1'b0);
    if (stray) begin
      check_done   = 1'b1;
      hit_neighbor = 1'b1;
    end
    @(negedge clk);
    check_done   = 1'b0;
    hit_neighbor = 1'b0;
    chk("move_latency", 32'(check_start), 1);
    chk("move_nowrite", 32'(vram_avn_write), 0);
    nx = int'(check_x);
    ny = int'(check_y);
    chk("step_adjacent", 32'(adjacent(px, py, nx, ny)), 1);
    px = nx;
    py = ny;
  endtask

  task automatic do_write(input int stall, input int exp_addr,
                          input int exp_cnt);
    bit seen;
    bit stable;
    logic [17:0] a0;
    seen   = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (vram_avn_write) seen = 1'b1;
      else @(negedge clk);
    end
    chk("write_seen", 32'(seen), 1);
    chk("write_addr", 32'(vram_avn_address), 32'(exp_addr));
    chk("write_data", 32'(vram_avn_writedata), 32'hFFFF);
    a0 = vram_avn_address;
    repeat (stall) begin
      @(negedge clk);
      if (!vram_avn_write || vram_avn_address !== a0
          || vram_avn_writedata !== 16'hFFFF) stable = 1'b0;
    end
    chk("write_hold", 32'(stable), 1);
    vram_avn_waitrequest = 1'b0;
    @(negedge clk);
    vram_avn_waitrequest = 1'b1;
    chk("write_end", 32'(vram_avn_write), 0);
    chk("write_cnt", 32'(particle_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  px;
    int  py;
    int  nx;
    int  ny;
    int  cnt_m;
    int  r;
    int  lat;
    bit  wr;
    bit  fin;
    bit  found;

    repeat (3) @(negedge clk);
    reset_checks("rst0");
    rst = 1'b0;

    // run 1: directed scenarios
    start_run("run1");
    chk("seed_addr_is_centre", 32'(check_x + check_y * HS),
        32'(SEED_ADDR));
    do_write(0, SEED_ADDR, 0);

    wait_check(px, py, wr);
    chk("spawn_range_a", 32'(in_range(px, py)), 1);
    respond($urandom_range(0, 3), 1'b1, 1'b1);
    wait_check(nx, ny, wr);
    chk("boundary_no_write", 32'(wr), 0);
    chk("respawn_range", 32'(in_range(nx, ny)), 1);
    px = nx;
    py = ny;

    // find a spawn two steps away from the edge, then stick on check 3
    found = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      if (px >= 2 && px <= HS - 3 && py >= 2 && py <= VS - 3) begin
        found = 1'b1;
      end else begin
        respond(0, 1'b1, 1'b0);
        wait_check(px, py, wr);
      end
    end
    chk("interior_spawn", 32'(found), 1);
    move_step($urandom_range(0, 3), 1'b0, px, py);
    move_step($urandom_range(0, 3), 1'b1, px, py);
    respond($urandom_range(0, 3), 1'b0, 1'b1);
    do_write(0, px + py * HS, 1);

    wait_check(px, py, wr);
    chk("spawn_range_b", 32'(in_range(px, py)), 1);
    respond(1, 1'b0, 1'b1);
    do_write(5, px + py * HS, 2);

    wait_check(px, py, wr);
    respond(0, 1'b0, 1'b1);
    do_write(0, px + py * HS, 3);
    chk("done_pulse", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
    @(negedge clk);
    chk("done_once", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_cnt", 32'(particle_cnt), 3);

    // run 2: randomized walk against the checker model
    start_run("run2");
    do_write($urandom_range(0, 3), SEED_ADDR, 0);
    cnt_m = 0;
    while (cnt_m < NP) begin
      wait_check(px, py, wr);
      chk("rnd_spawn_range", 32'(in_range(px, py)), 1);
      chk("rnd_spawn_nowrite", 32'(wr), 0);
      fin = 1'b0;
      for (int s = 0; s < 30 && !fin; s++) begin
        r   = $urandom_range(0, 7);
        lat = $urandom_range(0, 3);
        if (on_edge(px, py) || r == 0) begin
          respond(lat, 1'b1, 1'($urandom_range(0, 1)));
          fin = 1'b1;
        end else if (r == 1 || s == 29) begin
          respond(lat, 1'b0, 1'b1);
          cnt_m++;
          do_write($urandom_range(0, 3), px + py * HS, cnt_m);
          fin = 1'b1;
        end else begin
          move_step(lat, 1'b0, px, py);
        end
      end
    end
    chk("rnd_done", 32'(done), 1);
    @(negedge clk);

    // reset during WAIT
    start_run("run3");
    do_write(0, SEED_ADDR, 0);
    wait_check(px, py, wr);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    reset_checks("rst_wait");
    rst = 1'b0;

    // reset during a stalled write with one particle counted
    start_run("run4");
    do_write(0, SEED_ADDR, 0);
    wait_check(px, py, wr);
    respond(0, 1'b0, 1'b1);
    do_write(0, px + py * HS, 1);
    wait_check(px, py, wr);
    respond(0, 1'b0, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("stall_write", 32'(vram_avn_write), 1);
    chk("stall_addr", 32'(vram_avn_address), 32'(px + py * HS));
    chk("start_ignored_cnt", 32'(particle_cnt), 1);
    rst = 1'b1;
    @(negedge clk);
    reset_checks("rst_write");
    rst = 1'b0;

    start_run("run5");
    do_write(0, SEED_ADDR, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
